dcache_wt: RTL and testbench
============================

Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipelined core's MEM stage and a slow word-addressed backing memory.
- Consumes the MEM-stage address, write data and write enable, plus a read strobe.
- Returns read data in the same cycle on a hit.
- Raises stall to freeze the whole pipeline while a miss or a write is serviced over a valid/ready request and valid response memory port.

Parameters:
- LINES, 16, number of one-word lines; power of two, at least 2.
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- cpu_addr  input  ADDR_W  MEM-stage byte address (aluout); bits [1:0] ignored
- cpu_wdata  input  DATA_W  store data
- cpu_we  input  1  store request (memwrite)
- cpu_rd  input  1  load request (memtoreg)
- cpu_rdata  output  DATA_W  load data
- stall  output  1  pipeline hold
- mem_req_valid  output  1  request to backing memory
- mem_req_ready  input  1  backing memory accepts request
- mem_req_we  output  1  request is a write
- mem_req_addr  output  ADDR_W  word-aligned request address
- mem_req_wdata  output  DATA_W  write data
- mem_resp_valid  input  1  read data valid
- mem_resp_data  input  DATA_W  read data
- hit_count  output  32  load hits
- miss_count  output  32  load misses

Behaviour:
- Address split: index = addr[2+IDX_W-1:2], tag = addr[ADDR_W-1:2+IDX_W], IDX_W = log2(LINES).
- Reset (async, any state): all valid bits 0, state IDLE, counters 0, mem_req_valid 0. Outputs then:
  - stall = combinational function of IDLE and inputs;
  - cpu_rdata 0 while no hit;
  - mem_req_we/addr/wdata 0.
- An in-flight memory transaction is abandoned on reset. A mem_resp_valid arriving in IDLE is ignored.
- cpu_we and cpu_rd both high: treated as write; cpu_rd ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE, cpu_rd, hit: stall 0, cpu_rdata = line data combinationally, hit_count+1 at edge.
- IDLE, cpu_rd, miss: stall 1, miss_count+1, go RD_REQ.
- RD_REQ: mem_req_valid 1, we 0, addr = {cpu_addr[ADDR_W-1:2],2'b00}. On ready go RD_WAIT.
- RD_WAIT: on mem_resp_valid write data/tag, set valid, go IDLE. The next cycle is a hit (counted as hit): miss latency = accept + response + 1 cycle.
- IDLE, cpu_we: stall 1, go WR_REQ.
- WR_REQ: mem_req_valid 1, we 1, wdata = cpu_wdata. On ready, update line data if tag hit (no allocate on miss), go DONE.
- DONE: stall 0 for exactly one cycle so the store retires, then IDLE.
- Stall stays 1 in RD_REQ, RD_WAIT and WR_REQ.
- Request fields are held stable while mem_req_valid=1 and ready=0.
- Neither rd nor we in IDLE: stall 0, no memory activity.
- Counters wrap modulo 2^32.
- cpu_addr/cpu_wdata/cpu_we/cpu_rd are held constant by the stalled pipeline; the block does not latch them.

Decomposition:
- Shared package dcache_pkg holds:
  - state enum dcache_state_t;
  - IDX_W/TAG_W derivation functions;
  - the word-offset constant 2.
- One sub-module, dcache_array: valid/tag/data storage with asynchronous read, synchronous write, and async clear of valid bits on reset.

Test Plan:
- Reset, cold load of 0x40 with ready=1, response 2 cycles later, data 0xDEADBEEF -> stall 1 for 4 cycles, then cpu_rdata 0xDEADBEEF, stall 0; miss_count 1, hit_count 1.
- Repeat load of 0x40 -> stall 0 same cycle, rdata 0xDEADBEEF, no mem_req_valid, hit_count 2.
- Store 0x12345678 to 0x40 with ready delayed 3 cycles -> req fields stable for 3 cycles, stall low only in DONE; subsequent load of 0x40 hits with 0x12345678.
- Store to unmapped 0x80 then load 0x80 -> store writes memory only; load misses (miss_count+1).
- Conflict: load 0x40, then load 0x40+4*LINES (0x80 when LINES=16) -> second misses and evicts; reload of 0x40 misses.
- Assert reset during RD_WAIT, then send mem_resp_valid -> state IDLE, response ignored, all lines invalid, counters 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the write-through data cache.
package dcache_pkg;

    // Bytes-per-word shift: the low two address bits never reach the cache.
    localparam int WORD_OFF = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } dcache_state_t;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - WORD_OFF - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for a direct-mapped cache; async read, sync write.
// Zero-latency lookup; valid bits clear asynchronously on reset, tag/data are don't-care until filled.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [idx_w(LINES)-1:0]            rd_idx,
    output logic                               rd_valid,
    output logic [tag_w(ADDR_W, LINES)-1:0]    rd_tag,
    output logic [DATA_W-1:0]                  rd_data,
    input  logic                               wr_en,
    input  logic [idx_w(LINES)-1:0]            wr_idx,
    input  logic [tag_w(ADDR_W, LINES)-1:0]    wr_tag,
    input  logic [DATA_W-1:0]                  wr_data
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINES);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate D-cache between MEM stage and word memory.
// Load hits return data same cycle; misses and every store hold stall until the memory port completes.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_rd,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINES);

    dcache_state_t state_q, state_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] word_addr;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic              hit;
    logic              rd_hit;
    logic              rd_miss;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    assign idx       = cpu_addr[WORD_OFF +: IDX_W];
    assign tag       = cpu_addr[ADDR_W-1 -: TAG_W];
    assign word_addr = cpu_addr & ~ADDR_W'(3);

    dcache_array #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (wr_data)
    );

    assign hit = line_valid && (line_tag == tag);

    // A store with cpu_rd also high is a store; the load side is ignored.
    assign rd_hit  = (state_q == IDLE) && cpu_rd && !cpu_we && hit;
    assign rd_miss = (state_q == IDLE) && cpu_rd && !cpu_we && !hit;

    assign cpu_rdata = rd_hit ? line_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        wr_en         = 1'b0;
        wr_data       = mem_resp_data;
        case (state_q)
            IDLE: begin
                if (cpu_we) begin
                    stall   = 1'b1;
                    state_d = WR_REQ;
                end else if (rd_miss) begin
                    stall   = 1'b1;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_addr  = word_addr;
                if (mem_req_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    wr_en   = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = word_addr;
                mem_req_wdata = cpu_wdata;
                if (mem_req_ready) begin
                    // No allocate: only refresh a line already holding this word.
                    wr_en   = hit;
                    wr_data = cpu_wdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (rd_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (rd_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized bench for dcache_wt against an address-level cache/memory model.
module tb_dcache_wt;

    localparam int LINES  = 16;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic              cpu_rd;
    logic [DATA_W-1:0] cpu_rdata;
    logic              stall;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    always #5 clk = ~clk;

    dcache_wt #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_we         (cpu_we),
        .cpu_rd         (cpu_rd),
        .cpu_rdata      (cpu_rdata),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: backing memory by word address, and which word each line holds.
    logic [31:0] mem [bit [31:0]];
    bit          line_ok   [LINES];
    logic [31:0] line_addr [LINES];
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] w);
        if (mem.exists(w)) return mem[w];
        return (w * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
    endfunction

    task automatic check_counters();
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
    endtask

    task automatic do_load(input logic [31:0] a, input int rdy_dly, input int resp_dly);
        logic [31:0] w;
        int unsigned idx;
        bit was_hit;
        bit acc;
        bit done;
        int nstall;
        int rdy_wait;
        int since;
        w        = a & ~32'd3;
        idx      = (w >> 2) % LINES;
        was_hit  = line_ok[idx] && (line_addr[idx] == w);
        acc      = 1'b0;
        done     = 1'b0;
        nstall   = 0;
        rdy_wait = 0;
        since    = 0;
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = $urandom;
        cpu_rd    = 1'b1;
        cpu_we    = 1'b0;
        #1;
        for (int c = 0; c < 64 && !done; c++) begin
            if (!stall) begin
                done = 1'b1;
            end else begin
                nstall++;
                if (mem_req_valid) begin
                    chk("rd_req_we", 32'(mem_req_we), 32'd0);
                    chk("rd_req_addr", mem_req_addr, w);
                    if (rdy_wait == rdy_dly) begin
                        mem_req_ready = 1'b1;
                        acc = 1'b1;
                    end else begin
                        rdy_wait++;
                    end
                end else if (acc) begin
                    since++;
                    if (since == resp_dly) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = rd_mem(w);
                    end
                end
                @(negedge clk);
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b0;
                mem_resp_data  = $urandom;
                #1;
            end
        end
        if (!done) chk("load_timeout", 32'd0, 32'd1);
        chk("load_stall_cycles", 32'(nstall), was_hit ? 32'd0 : 32'(2 + rdy_dly + resp_dly));
        chk("load_rdata", cpu_rdata, rd_mem(w));
        chk("load_no_req", 32'(mem_req_valid), 32'd0);
        if (!was_hit) begin
            exp_misses     = exp_misses + 32'd1;
            line_ok[idx]   = 1'b1;
            line_addr[idx] = w;
        end
        exp_hits = exp_hits + 32'd1;
        @(negedge clk);
        cpu_rd = 1'b0;
        #1;
        check_counters();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int rdy_dly);
        logic [31:0] w;
        bit done;
        int nstall;
        int rdy_wait;
        w        = a & ~32'd3;
        done     = 1'b0;
        nstall   = 0;
        rdy_wait = 0;
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        cpu_rd    = 1'($urandom_range(0, 1));
        #1;
        for (int c = 0; c < 64 && !done; c++) begin
            if (!stall) begin
                done = 1'b1;
            end else begin
                nstall++;
                if (mem_req_valid) begin
                    chk("wr_req_we", 32'(mem_req_we), 32'd1);
                    chk("wr_req_addr", mem_req_addr, w);
                    chk("wr_req_wdata", mem_req_wdata, d);
                    if (rdy_wait == rdy_dly) begin
                        mem_req_ready = 1'b1;
                    end else begin
                        rdy_wait++;
                    end
                end
                @(negedge clk);
                mem_req_ready = 1'b0;
                #1;
            end
        end
        if (!done) chk("store_timeout", 32'd0, 32'd1);
        chk("store_stall_cycles", 32'(nstall), 32'(2 + rdy_dly));
        chk("store_done_no_req", 32'(mem_req_valid), 32'd0);
        mem[w] = d;
        @(negedge clk);
        cpu_we = 1'b0;
        cpu_rd = 1'b0;
        #1;
        chk("after_store_stall", 32'(stall), 32'd0);
        check_counters();
    endtask

    task automatic do_idle();
        @(negedge clk);
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        cpu_rd    = 1'b0;
        cpu_we    = 1'b0;
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_req", 32'(mem_req_valid), 32'd0);
        check_counters();
    endtask

    initial begin
        logic [31:0] a;
        int op;
        reset          = 1'b1;
        cpu_addr       = '0;
        cpu_wdata      = '0;
        cpu_we         = 1'b0;
        cpu_rd         = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        exp_hits       = '0;
        exp_misses     = '0;
        for (int i = 0; i < LINES; i++) begin
            line_ok[i]   = 1'b0;
            line_addr[i] = '0;
        end
        #1;
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed scenarios.
        mem[32'h40] = 32'hDEAD_BEEF;
        do_load(32'h40, 0, 2);
        do_load(32'h40, 0, 1);
        do_store(32'h40, 32'h1234_5678, 3);
        do_load(32'h40, 0, 1);
        do_store(32'h80, 32'hCAFE_F00D, 1);
        do_load(32'h80, 0, 1);
        do_load(32'h40, 1, 1);
        do_idle();

        // Reset while a fill is outstanding; the late response must be ignored.
        @(negedge clk);
        cpu_addr = 32'h0000_0104;
        cpu_rd   = 1'b1;
        #1;
        chk("rw_idle_miss_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        chk("rw_rd_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        chk("rw_wait_stall", 32'(stall), 32'd1);
        chk("rw_wait_no_req", 32'(mem_req_valid), 32'd0);
        cpu_rd = 1'b0;
        reset  = 1'b1;
        #1;
        exp_hits   = '0;
        exp_misses = '0;
        for (int i = 0; i < LINES; i++) line_ok[i] = 1'b0;
        chk("rw_rst_stall", 32'(stall), 32'd0);
        check_counters();
        @(negedge clk);
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("rw_after_resp_req", 32'(mem_req_valid), 32'd0);
        chk("rw_after_resp_stall", 32'(stall), 32'd0);
        check_counters();
        do_load(32'h40, 0, 1);
        do_load(32'h0000_0104, 0, 1);

        // Random mix over a small address pool so lines conflict often.
        for (int n = 0; n < 150; n++) begin
            a  = 32'($urandom_range(0, 3) * LINES * 4 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
            op = $urandom_range(0, 5);
            if (op < 3) begin
                do_load(a, $urandom_range(0, 3), $urandom_range(1, 3));
            end else if (op < 5) begin
                do_store(a, $urandom, $urandom_range(0, 3));
            end else begin
                do_idle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
